// File: rtl/uart_term_pkg.sv
// Shared constants, state encodings and the character filter used by the
// UART-to-terminal bridge.
package uart_term_pkg;

  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_TILDE = 7'h7E;
  localparam logic [6:0] LOWER_A     = 7'h61;
  localparam logic [6:0] LOWER_Z     = 7'h7A;
  localparam logic [6:0] CASE_OFFSET = 7'h20;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  localparam logic [1:0] HS_IDLE    = 2'd0;
  localparam logic [1:0] HS_SETUP   = 2'd1;
  localparam logic [1:0] HS_PRESENT = 2'd2;
  localparam logic [1:0] HS_RELEASE = 2'd3;

  typedef struct packed {
    logic       keep;
    logic [6:0] ch;
  } filt_t;

  // Caller passes the 7 low bits; bit 7 of the received byte is always ignored.
  function automatic filt_t filter_char(input logic [6:0] b, input logic upcase);
    filt_t f;
    f.ch = b;
    if (upcase && (f.ch >= LOWER_A) && (f.ch <= LOWER_Z)) begin
      f.ch = f.ch - CASE_OFFSET;
    end
    f.keep = (f.ch == ASCII_CR) || ((f.ch >= ASCII_SPACE) && (f.ch <= ASCII_TILDE));
    return f;
  endfunction

endpackage

// File: rtl/uart_term_bridge_if.sv
// Character handshake between the bridge (master) and the video terminal (slave).
interface uart_term_bridge_if;
  logic [7:1] rd;
  logic       da;
  logic       rda_n;

  modport master (output rd, output da, input rda_n);
  modport slave  (input rd, input da, output rda_n);
endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: input synchronizer, bit-period divider, RX FSM and sticky framing error.
module uart_rx
  import uart_term_pkg::*;
#(
  parameter int CLK_HZ = 14318180,
  parameter int BAUD   = 115200
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);

  logic [1:0]       rxd_sync_reg;
  logic             rxd_prev_reg;
  logic             rxd_s;
  logic [2:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             valid_reg;
  logic             frame_err_reg;

  assign rxd_s      = rxd_sync_reg[1];
  assign byte_valid = valid_reg;
  assign byte_data  = shift_reg;
  assign frame_err  = frame_err_reg;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rxd_sync_reg  <= 2'b11;
      rxd_prev_reg  <= 1'b1;
      state_reg     <= RX_IDLE;
      cnt_reg       <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rxd_sync_reg <= {rxd_sync_reg[0], rxd};
      rxd_prev_reg <= rxd_s;
      valid_reg    <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          if (rxd_prev_reg && !rxd_s) begin
            state_reg <= RX_START;
            cnt_reg   <= '0;
          end
        end
        // Re-check the start bit at its midpoint so short glitches are ignored.
        RX_START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg     <= '0;
            shift_reg   <= {rxd_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= RX_STOP;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_reg <= '0;
            if (rxd_s) begin
              valid_reg <= 1'b1;
              state_reg <= RX_IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_s) begin
            state_reg <= RX_IDLE;
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_term_bridge.sv
// Host UART to video-terminal bridge: receive, filter/upcase, buffer in a FIFO,
// then hand characters to the terminal over the rd/da/rda_n handshake.
module uart_term_bridge
  import uart_term_pkg::*;
#(
  parameter int CLK_HZ     = 14318180,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter bit UPCASE     = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  rxd,
  uart_term_bridge_if.master    term,
  output logic                  fifo_full,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        unused_msb;
  filt_t       filt;

  logic [6:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] wr_ptr_next, rd_ptr_next;
  logic        fifo_empty, fifo_full_now;
  logic        push_req, push, pop;

  logic [1:0]  rda_sync_reg;
  logic [1:0]  hs_state_reg;
  logic [6:0]  rd_reg;
  logic        da_reg;
  logic        fifo_full_reg;
  logic        overrun_reg;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk_in     (clk_in),
    .rst        (rst),
    .rxd        (rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign unused_msb = byte_data[7];
  assign filt       = filter_char(byte_data[6:0], UPCASE);

  assign fifo_empty    = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full_now = ((wr_ptr_reg - rd_ptr_reg) == DEPTH_CNT);
  assign pop           = (hs_state_reg == HS_IDLE) && !fifo_empty;
  assign push_req      = byte_valid && filt.keep;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push          = push_req && (!fifo_full_now || pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= filt.ch;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rda_sync_reg  <= 2'b11;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_full_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      hs_state_reg  <= HS_IDLE;
      rd_reg        <= '0;
      da_reg        <= 1'b0;
    end else begin
      rda_sync_reg  <= {rda_sync_reg[0], term.rda_n};
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      fifo_full_reg <= ((wr_ptr_next - rd_ptr_next) == DEPTH_CNT);
      if (push_req && !push) begin
        overrun_reg <= 1'b1;
      end
      // rd only moves in IDLE, one cycle before da can rise.
      case (hs_state_reg)
        HS_IDLE: begin
          if (pop) begin
            rd_reg       <= mem[rd_ptr_reg[AW-1:0]];
            hs_state_reg <= HS_SETUP;
          end
        end
        HS_SETUP: begin
          da_reg       <= 1'b1;
          hs_state_reg <= HS_PRESENT;
        end
        HS_PRESENT: begin
          if (!rda_sync_reg[1]) begin
            da_reg       <= 1'b0;
            hs_state_reg <= HS_RELEASE;
          end
        end
        HS_RELEASE: begin
          if (rda_sync_reg[1]) begin
            hs_state_reg <= HS_IDLE;
          end
        end
        default: begin
          da_reg       <= 1'b0;
          hs_state_reg <= HS_IDLE;
        end
      endcase
    end
  end

  assign term.rd   = rd_reg;
  assign term.da   = da_reg;
  assign fifo_full = fifo_full_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_term_bridge.sv
// Directed bench for uart_term_bridge: serial stimulus on rxd, terminal-side
// handshake on rda_n, expected characters and flags written out by hand.
`timescale 1ns/1ps
module tb_uart_term_bridge;

    localparam int CLK_HZ     = 1_600_000;
    localparam int BAUD       = 100_000;
    localparam int DIV        = 16;
    localparam int FIFO_DEPTH = 16;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic rxd    = 1'b1;
    logic fifo_full, overrun, frame_err;

    int checks = 0;
    int errors = 0;

    uart_term_bridge_if term_if ();

    uart_term_bridge #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH),
        .UPCASE     (1'b1)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .rxd       (rxd),
        .term      (term_if),
        .fifo_full (fifo_full),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk_in = ~clk_in;

    // Terminal-side monitor: how long rd was stable when da rose, and any rd change while da high.
    logic [6:0] mon_rd_q = 7'h00;
    logic       mon_da_q = 1'b0;
    int         rd_stable = 0;
    int         setup_at_rise = -1;
    int         rd_change_while_da = 0;

    always @(negedge clk_in) begin
        mon_rd_q  <= term_if.rd;
        mon_da_q  <= term_if.da;
        rd_stable <= (term_if.rd !== mon_rd_q) ? 0 : rd_stable + 1;
        if (term_if.da && !mon_da_q)
            setup_at_rise <= (term_if.rd !== mon_rd_q) ? 0 : rd_stable + 1;
        if (term_if.da && mon_da_q && (term_if.rd !== mon_rd_q))
            rd_change_while_da <= rd_change_while_da + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk_in);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk_in);
        end
        rxd = stop_bit;
        repeat (DIV) @(negedge clk_in);
        rxd = 1'b1;
        repeat (DIV / 2) @(negedge clk_in);
    endtask

    task automatic wait_da(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            if (term_if.da === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic recv_check(input string tag, input logic [6:0] exp);
        bit ok1, ok2;
        logic [6:0] c;
        wait_da(1'b1, ok1);
        c = term_if.rd;
        repeat (3) @(negedge clk_in);
        term_if.rda_n = 1'b0;
        wait_da(1'b0, ok2);
        term_if.rda_n = 1'b1;
        check({tag, "_handshake"}, {31'd0, ok1 && ok2}, 32'd1);
        check(tag, {25'd0, c}, {25'd0, exp});
    endtask

    initial begin
        bit ok;
        term_if.rda_n = 1'b1;
        rst = 1'b1;
        rxd = 1'b1;
        repeat (4) @(negedge clk_in);

        check("reset_rd",        {25'd0, term_if.rd}, 32'h0);
        check("reset_da",        {31'd0, term_if.da}, 32'h0);
        check("reset_fifo_full", {31'd0, fifo_full},  32'h0);
        check("reset_overrun",   {31'd0, overrun},    32'h0);
        check("reset_frame_err", {31'd0, frame_err},  32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk_in);

        // Single char, slow terminal acknowledge, second char held back until rda_n returns high.
        send_byte(8'h41, 1'b1);
        wait_da(1'b1, ok);
        check("t1_da_rise", {31'd0, ok}, 32'd1);
        check("t1_rd", {25'd0, term_if.rd}, 32'h41);
        @(negedge clk_in);
        check("t1_rd_setup", {31'd0, setup_at_rise >= 1}, 32'd1);
        repeat (20) @(negedge clk_in);
        check("t1_da_held", {31'd0, term_if.da}, 32'd1);
        send_byte(8'h43, 1'b1);
        check("t1_rd_hold", {25'd0, term_if.rd}, 32'h41);
        term_if.rda_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            if (term_if.da === 1'b0) break;
        end
        check("t1_da_drop_3cyc", {31'd0, term_if.da}, 32'd0);
        repeat (10) @(negedge clk_in);
        check("t1_no_next_while_ack", {31'd0, term_if.da}, 32'd0);
        check("t1_rd_still_a", {25'd0, term_if.rd}, 32'h41);
        term_if.rda_n = 1'b1;
        recv_check("t1_second", 7'h43);

        // Filter and upcase: a z LF CR DEL -> A Z CR.
        send_byte(8'h61, 1'b1);
        send_byte(8'h7A, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0D, 1'b1);
        send_byte(8'h7F, 1'b1);
        recv_check("t2_a_up", 7'h41);
        recv_check("t2_z_up", 7'h5A);
        recv_check("t2_cr",   7'h0D);
        repeat (100) @(negedge clk_in);
        check("t2_no_extra", {31'd0, term_if.da}, 32'd0);

        // Quarter-bit glitch on rxd.
        @(negedge clk_in);
        rxd = 1'b0;
        repeat (DIV / 4) @(negedge clk_in);
        rxd = 1'b1;
        repeat (60) @(negedge clk_in);
        check("t5_glitch_da",        {31'd0, term_if.da}, 32'd0);
        check("t5_glitch_frame_err", {31'd0, frame_err},  32'd0);
        check("t5_glitch_overrun",   {31'd0, overrun},    32'd0);

        // Fill with the terminal stalled: 1 in rd + 16 buffered, 18th overruns.
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            send_byte(8'h30 + 8'(i), 1'b1);
            if (i == FIFO_DEPTH - 1)
                check("t3_not_full_yet", {31'd0, fifo_full}, 32'd0);
            if (i == FIFO_DEPTH) begin
                check("t3_full",           {31'd0, fifo_full}, 32'd1);
                check("t3_no_overrun_yet", {31'd0, overrun},   32'd0);
            end
        end
        check("t3_overrun",    {31'd0, overrun},   32'd1);
        check("t3_full_after", {31'd0, fifo_full}, 32'd1);
        for (int i = 0; i <= FIFO_DEPTH; i++)
            recv_check($sformatf("t3_char%0d", i), 7'h30 + 7'(i));
        repeat (100) @(negedge clk_in);
        check("t3_drained_da",   {31'd0, term_if.da}, 32'd0);
        check("t3_drained_full", {31'd0, fifo_full},  32'd0);

        // Asynchronous reset while da is high.
        send_byte(8'h58, 1'b1);
        wait_da(1'b1, ok);
        check("t6_da_rise", {31'd0, ok}, 32'd1);
        check("t6_overrun_sticky", {31'd0, overrun}, 32'd1);
        @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_da",        {31'd0, term_if.da}, 32'd0);
        check("t6_rst_rd",        {25'd0, term_if.rd}, 32'h0);
        check("t6_rst_overrun",   {31'd0, overrun},    32'd0);
        check("t6_rst_fifo_full", {31'd0, fifo_full},  32'd0);
        check("t6_rst_frame_err", {31'd0, frame_err},  32'd0);
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        send_byte(8'h79, 1'b1);
        recv_check("t6_after_reset", 7'h59);

        // Framing error: byte discarded, next byte delivered, flag sticky.
        send_byte(8'h55, 1'b0);
        repeat (20) @(negedge clk_in);
        check("t4_frame_err",   {31'd0, frame_err},  32'd1);
        check("t4_no_delivery", {31'd0, term_if.da}, 32'd0);
        check("t4_no_overrun",  {31'd0, overrun},    32'd0);
        send_byte(8'h42, 1'b1);
        recv_check("t4_next_char", 7'h42);
        check("t4_frame_err_sticky", {31'd0, frame_err}, 32'd1);

        @(negedge clk_in);
        check("rd_stable_while_da", rd_change_while_da, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
